riscv_core_muldiv_unit: RTL and testbench

- Iterative M-extension execute unit for the RV64 core. Sits beside the integer ALU in the execute stage.
- Consumes the same decoded funct3 / opcode fields that drive ALU control. Produces MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and their W variants.
- Multi-cycle: the execute stage stalls on o_muldiv_busy and captures the result on o_muldiv_done.

---
 rtl/riscv_core_muldiv_unit_pkg.sv | 29 ++
 rtl/riscv_core_muldiv_unit_if.sv | 29 ++
 rtl/riscv_core_muldiv_operand_prep.sv | 57 +++++
 rtl/riscv_core_muldiv_unit.sv | 179 +++++++++++++++++
 tb/tb_riscv_core_muldiv_unit.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/riscv_core_muldiv_unit_pkg.sv
// Shared types and constants for the RV64 M-extension execute unit.
// Holds the op/state enums, counter width and W-result sign extension.
package riscv_core_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

endpackage

// File: rtl/riscv_core_muldiv_unit_if.sv
// Execute-stage <-> mul/div unit bundle: op request, flush, busy/done/result.
// The execute stage drives the master side; the unit is the slave.
interface riscv_core_muldiv_unit_if
    import riscv_core_pkg::*;
#(
    parameter int XLEN = riscv_core_pkg::XLEN
);
    logic            i_muldiv_start;
    logic [2:0]      i_muldiv_funct3;
    logic            i_muldiv_word;
    logic [XLEN-1:0] i_muldiv_rs1;
    logic [XLEN-1:0] i_muldiv_rs2;
    logic            i_muldiv_flush;
    logic            o_muldiv_busy;
    logic            o_muldiv_done;
    logic [XLEN-1:0] o_muldiv_result;

    modport master (
        output i_muldiv_start, i_muldiv_funct3, i_muldiv_word,
        output i_muldiv_rs1, i_muldiv_rs2, i_muldiv_flush,
        input  o_muldiv_busy, o_muldiv_done, o_muldiv_result
    );

    modport slave (
        input  i_muldiv_start, i_muldiv_funct3, i_muldiv_word,
        input  i_muldiv_rs1, i_muldiv_rs2, i_muldiv_flush,
        output o_muldiv_busy, o_muldiv_done, o_muldiv_result
    );
endinterface

// File: rtl/riscv_core_muldiv_operand_prep.sv
// Operand conditioning: W extension, signedness, magnitudes,
// and divide-by-zero / signed-overflow detection.
module riscv_core_muldiv_operand_prep
    import riscv_core_pkg::*;
#(
    parameter int XLEN = riscv_core_pkg::XLEN
) (
    input  logic [2:0]      funct3,
    input  logic            word,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output muldiv_op_e      op,
    output logic            is_div,
    output logic [XLEN-1:0] a_ext,
    output logic [XLEN-1:0] a_mag,
    output logic [XLEN-1:0] b_mag,
    output logic            a_neg,
    output logic            b_neg,
    output logic            b_zero,
    output logic            div_ovf
);
    logic            a_sgn;
    logic            b_sgn;
    logic [XLEN-1:0] b_ext;
    logic            min_ovf;

    always_comb begin
        op = muldiv_op_e'(funct3);
        // W forms of the high-half multiplies collapse onto MULW
        if (word && !funct3[2]) op = OP_MUL;
        is_div = op[2];
        a_sgn  = 1'b0;
        b_sgn  = 1'b0;
        unique case (op)
            OP_MULH:        begin a_sgn = 1'b1; b_sgn = 1'b1; end
            OP_MULHSU:      a_sgn = 1'b1;
            OP_DIV, OP_REM: begin a_sgn = 1'b1; b_sgn = 1'b1; end
            default:        ;
        endcase
        if (word) begin
            a_ext = {{(XLEN-32){a_sgn & rs1[31]}}, rs1[31:0]};
            b_ext = {{(XLEN-32){b_sgn & rs2[31]}}, rs2[31:0]};
            min_ovf = (rs1[31:0] == 32'h8000_0000) && (rs2[31:0] == 32'hFFFF_FFFF);
        end else begin
            a_ext = rs1;
            b_ext = rs2;
            min_ovf = (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == {XLEN{1'b1}});
        end
        a_neg   = a_sgn & a_ext[XLEN-1];
        b_neg   = b_sgn & b_ext[XLEN-1];
        a_mag   = a_neg ? -a_ext : a_ext;
        b_mag   = b_neg ? -b_ext : b_ext;
        b_zero  = (b_ext == '0);
        div_ovf = is_div & a_sgn & min_ovf;
    end

endmodule

// File: rtl/riscv_core_muldiv_unit.sv
// Iterative RV64 M-extension unit: radix-2 multiply, restoring divide.
// RV_MULDIV_FAST_MUL_EN makes every multiply a single-cycle fast-path op.
module riscv_core_muldiv_unit
    import riscv_core_pkg::*;
#(
    parameter int XLEN = riscv_core_pkg::XLEN
) (
    input logic i_clk,
    input logic i_rst,
    riscv_core_muldiv_unit_if.slave mdif
);
    muldiv_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_nxt;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   res_q, res_d;
    muldiv_op_e        op_q, op_d;
    logic              word_q, word_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;

    muldiv_op_e      p_op;
    logic            p_is_div;
    logic [XLEN-1:0] p_a_ext, p_a_mag, p_b_mag;
    logic            p_a_neg, p_b_neg, p_b_zero, p_ovf;

    riscv_core_muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
        .funct3  (mdif.i_muldiv_funct3),
        .word    (mdif.i_muldiv_word),
        .rs1     (mdif.i_muldiv_rs1),
        .rs2     (mdif.i_muldiv_rs2),
        .op      (p_op),
        .is_div  (p_is_div),
        .a_ext   (p_a_ext),
        .a_mag   (p_a_mag),
        .b_mag   (p_b_mag),
        .a_neg   (p_a_neg),
        .b_neg   (p_b_neg),
        .b_zero  (p_b_zero),
        .div_ovf (p_ovf)
    );

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     rem_diff;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fin_raw, fin_res;

    // One iteration: acc holds {hi, multiplier} or {remainder, quotient}
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, b_q};
        if (op_q[2]) begin
            acc_nxt = rem_diff[XLEN]
                ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                : {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_nxt = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    always_comb begin
        // 32 iterations leave a W product 32 bits above its final place
        prod     = word_q ? (acc_nxt >> 32) : acc_nxt;
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem_fix  = rneg_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        unique case (op_q)
            OP_MUL:                       fin_raw = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_raw = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fin_raw = quo_fix;
            default:                      fin_raw = rem_fix;
        endcase
        fin_res = word_q ? sext_w(fin_raw) : fin_raw;
    end

    logic            fast_hit;
    logic [XLEN-1:0] fast_quo, fast_rem, fast_raw, fast_res;
`ifdef RV_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fmul_mag, fmul;
`endif

    always_comb begin
        fast_hit = p_is_div & (p_b_zero | p_ovf);
        fast_quo = p_b_zero ? '1 : p_a_ext;
        fast_rem = p_b_zero ? p_a_ext : '0;
        fast_raw = p_op[1] ? fast_rem : fast_quo;
`ifdef RV_MULDIV_FAST_MUL_EN
        fmul_mag = {{XLEN{1'b0}}, p_a_mag} * {{XLEN{1'b0}}, p_b_mag};
        fmul     = (p_a_neg ^ p_b_neg) ? -fmul_mag : fmul_mag;
        if (!p_is_div) begin
            fast_hit = 1'b1;
            fast_raw = (p_op == OP_MUL) ? fmul[XLEN-1:0] : fmul[2*XLEN-1:XLEN];
        end
`endif
        fast_res = mdif.i_muldiv_word ? sext_w(fast_raw) : fast_raw;
    end

    logic accept;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        res_d   = res_q;
        op_d    = op_q;
        word_d  = word_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        accept  = mdif.i_muldiv_start & ~mdif.i_muldiv_flush;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    op_d   = p_op;
                    word_d = mdif.i_muldiv_word;
                    neg_d  = p_a_neg ^ p_b_neg;
                    rneg_d = p_a_neg;
                    b_d    = p_b_mag;
                    if (fast_hit) begin
                        state_d = DONE;
                        res_d   = fast_res;
                    end else begin
                        state_d = CALC;
                        cnt_d   = mdif.i_muldiv_word ? CNT_W'(32) : CNT_W'(XLEN);
                        if (p_is_div && mdif.i_muldiv_word)
                            acc_d = {{XLEN{1'b0}}, p_a_mag[31:0], {(XLEN-32){1'b0}}};
                        else
                            acc_d = {{XLEN{1'b0}}, p_a_mag};
                    end
                end
            end
            CALC: begin
                acc_d = acc_nxt;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    res_d   = fin_res;
                end
            end
            default: state_d = IDLE;
        endcase
        if (mdif.i_muldiv_flush) begin
            state_d = IDLE;
            res_d   = res_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= OP_MUL;
            word_q  <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            res_q   <= res_d;
            op_q    <= op_d;
            word_q  <= word_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign mdif.o_muldiv_busy   = (state_q == CALC);
    assign mdif.o_muldiv_done   = (state_q == DONE);
    assign mdif.o_muldiv_result = res_q;

endmodule

// File: tb/tb_riscv_core_muldiv_unit.sv
// Directed bench for riscv_core_muldiv_unit: results, latency, fast path,
// flush/start/reset rules. Honors RV_MULDIV_FAST_MUL_EN for multiply latency.
module tb_riscv_core_muldiv_unit;
    import riscv_core_pkg::*;

`ifdef RV_MULDIV_FAST_MUL_EN
    localparam int ML  = 1;
    localparam int MLW = 1;
`else
    localparam int ML  = 65;
    localparam int MLW = 33;
`endif

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    riscv_core_muldiv_unit_if mdif ();

    riscv_core_muldiv_unit dut (
        .i_clk (clk),
        .i_rst (rst),
        .mdif  (mdif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] f3, input logic w,
                         input logic [63:0] a, input logic [63:0] b);
        mdif.i_muldiv_funct3 = f3;
        mdif.i_muldiv_word   = w;
        mdif.i_muldiv_rs1    = a;
        mdif.i_muldiv_rs2    = b;
        mdif.i_muldiv_start  = 1'b1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic w,
                         input logic [63:0] a, input logic [63:0] b);
        drive(f3, w, a, b);
        @(negedge clk);
        mdif.i_muldiv_start = 1'b0;
    endtask

    // Called at a negedge in cycle n0; returns the cycle done is seen in
    task automatic wait_done(input int n0, output int cyc, output logic bok);
        int n;
        n   = n0;
        bok = 1'b1;
        cyc = -1;
        while (n <= 200) begin
            if (mdif.o_muldiv_done === 1'b1) begin
                cyc = n;
                if (mdif.o_muldiv_busy !== 1'b0) bok = 1'b0;
                break;
            end
            if (mdif.o_muldiv_busy !== 1'b1) bok = 1'b0;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] f3, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_res, input int exp_cyc);
        int   cyc;
        logic bok;
        issue(f3, w, a, b);
        wait_done(1, cyc, bok);
        chk({tag, "_cyc"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, "_res"}, mdif.o_muldiv_result, exp_res);
        chk({tag, "_busy"}, {63'd0, bok}, 64'd1);
        @(negedge clk);
        chk({tag, "_pulse"}, {63'd0, mdif.o_muldiv_done}, 64'd0);
    endtask

    task automatic no_done(input string tag, input int ncyc);
        int seen;
        seen = 0;
        repeat (ncyc) begin
            if (mdif.o_muldiv_done !== 1'b0) seen++;
            @(negedge clk);
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        int   cyc;
        logic bok;

        rst = 1'b1;
        mdif.i_muldiv_start  = 1'b0;
        mdif.i_muldiv_flush  = 1'b0;
        mdif.i_muldiv_funct3 = 3'd0;
        mdif.i_muldiv_word   = 1'b0;
        mdif.i_muldiv_rs1    = 64'd0;
        mdif.i_muldiv_rs2    = 64'd0;
        #1;
        chk("rst_busy", {63'd0, mdif.o_muldiv_busy}, 64'd0);
        chk("rst_done", {63'd0, mdif.o_muldiv_done}, 64'd0);
        chk("rst_res", mdif.o_muldiv_result, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_op("mul", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, ML);
        do_op("mulhu", 3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, ML);
        do_op("mulhsu", 3'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, ML);
        do_op("mulh", 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, ML);
        do_op("div", 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        do_op("rem", 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        do_op("divu", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65);
        do_op("remu", 3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65);

        do_op("divu_z", 3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        do_op("rem_z", 3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1);
        do_op("div_ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
        do_op("rem_ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);

        do_op("mulw", 3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MLW);
        do_op("mulhuw", 3'd3, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MLW);
        do_op("divw_ovf", 3'd4, 1'b1, 64'h1_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1);
        do_op("divuw", 3'd5, 1'b1, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        do_op("remw_z", 3'd6, 1'b1, 64'h1_8000_0001, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0001, 1);

        // Flush in cycle 10 of a DIV
        issue(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        repeat (9) @(negedge clk);
        mdif.i_muldiv_flush = 1'b1;
        @(negedge clk);
        mdif.i_muldiv_flush = 1'b0;
        chk("flush_busy", {63'd0, mdif.o_muldiv_busy}, 64'd0);
        no_done("flush_nodone", 70);
        chk("flush_res", mdif.o_muldiv_result, 64'hFFFF_FFFF_8000_0001);

        // Start together with flush is dropped
        drive(3'd5, 1'b0, 64'd100, 64'd7);
        mdif.i_muldiv_flush = 1'b1;
        @(negedge clk);
        mdif.i_muldiv_start = 1'b0;
        mdif.i_muldiv_flush = 1'b0;
        chk("sf_busy", {63'd0, mdif.o_muldiv_busy}, 64'd0);
        no_done("sf_nodone", 70);

        // Start during CALC is ignored
        issue(3'd5, 1'b0, 64'd100, 64'd7);
        repeat (4) @(negedge clk);
        issue(3'd5, 1'b0, 64'd5, 64'd0);
        wait_done(6, cyc, bok);
        chk("ign_cyc", 64'(cyc), 64'd65);
        chk("ign_res", mdif.o_muldiv_result, 64'd14);

        // Back-to-back: start in DONE into fast path, then into CALC
        drive(3'd6, 1'b0, 64'd5, 64'd0);
        @(negedge clk);
        mdif.i_muldiv_start = 1'b0;
        chk("b2b_fast_done", {63'd0, mdif.o_muldiv_done}, 64'd1);
        chk("b2b_fast_res", mdif.o_muldiv_result, 64'd5);
        drive(3'd5, 1'b0, 64'd200, 64'd7);
        @(negedge clk);
        mdif.i_muldiv_start = 1'b0;
        chk("b2b_busy", {63'd0, mdif.o_muldiv_busy}, 64'd1);
        wait_done(1, cyc, bok);
        chk("b2b_cyc", 64'(cyc), 64'd65);
        chk("b2b_res", mdif.o_muldiv_result, 64'd28);
        @(negedge clk);

        // Reset pulse mid-op
        issue(3'd4, 1'b0, 64'd100, 64'd7);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_busy", {63'd0, mdif.o_muldiv_busy}, 64'd0);
        chk("mrst_done", {63'd0, mdif.o_muldiv_done}, 64'd0);
        chk("mrst_res", mdif.o_muldiv_result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        no_done("mrst_nodone", 70);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
